round_key_store: RTL
====================

ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 Parameters: NUM_KEYS, 11, number of stored round keys; KEY_W, 128, round-key width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 wr_addr  input  4  write address from key expander; 1..11 = key index, 0 = no write.
REQ-005 wr_key  input  KEY_W  round key accompanying wr_addr.
REQ-006 wr_loaded  input  1  expander signals full schedule written.
REQ-007 start  input  1  one-cycle request to stream all keys.
REQ-008 decrypt  input  1  stream order, sampled with start: 0 = keys 1..11, 1 = keys 11..1.
REQ-009 key_ready  input  1  consumer accepts key_out this cycle.
REQ-010 key_out  output  KEY_W  registered round key being offered.
REQ-011 key_round  output  4  index (1..11) of key on key_out; 0 when key_valid low.
REQ-012 key_valid  output  1  key_out/key_round valid.
REQ-013 keys_ready  output  1  full valid schedule held; start will be accepted.
REQ-014 busy  output  1  stream in progress (FSM in STREAM).

Function
REQ-015 Write: wr_addr in 1..11 SHALL store wr_key into entry wr_addr and set valid bit wr_addr at the next edge; wr_addr 0 or 12..15 SHALL be ignored.
REQ-016 wr_addr==1 SHALL mark a new schedule: valid bitmap becomes {only bit 1 set} and keys_ready clears the next cycle.
REQ-017 keys_ready SHALL be registered: next value = wr_loaded AND all 11 valid bits set AND no wr_addr==1 this cycle.
REQ-018 FSM states IDLE, STREAM; IDLE -> STREAM when start & keys_ready; start while busy or !keys_ready SHALL be ignored.
REQ-019 Latency: start accepted at edge N -> key_valid=1 with first key at cycle N+1 (key 1 if decrypt=0, key 11 if decrypt=1).
REQ-020 Handshake: transfer when key_valid & key_ready; while key_valid & !key_ready, key_out and key_round SHALL hold.
REQ-021 On transfer of a non-final key, next cycle SHALL present the next index (+1 encrypt, -1 decrypt) with no bubble.
REQ-022 On transfer of the final key (11 encrypt, 1 decrypt), FSM -> IDLE, key_valid=0 and key_round=0 the next cycle; busy falls on the same edge.
REQ-023 decrypt SHALL be latched at start; changes during STREAM SHALL have no effect.
REQ-024 wr_addr==1 during STREAM SHALL abort: FSM -> IDLE, key_valid=0 next cycle, no further keys offered.
REQ-025 Writes to addr 2..11 during STREAM SHALL update storage; a key already on key_out SHALL not change.
REQ-026 Simultaneous start and wr_addr==1 in IDLE: write wins, start ignored.

Reset
REQ-027 On rst: FSM IDLE, valid bitmap 0, key_valid 0, key_round 0, key_out 0, keys_ready 0, busy 0.
REQ-028 Key storage SHALL not be reset; contents invalid until rewritten.
REQ-029 rst mid-stream SHALL terminate the stream with outputs at reset values the following cycle.

Structure
REQ-030 Shared package aes_pkg holds NUM_ROUND_KEYS=11, KEY_W=128, KEY_ADDR_W=4 and FSM state encoding.
REQ-031 Storage SHALL be a sub-module round_key_regfile (11 x 128 registers, one write port, one read port); FSM and handshake in round_key_store.

Verification
REQ-032 Load FIPS-197 key 000102030405060708090a0b0c0d0e0f schedule via wr_addr 1..11, then wr_loaded=1 -> keys_ready=1 one cycle later.
REQ-033 Encrypt, key_ready=1: start at edge N -> key_valid high cycles N+1..N+11, key_round 1..11, first key_out 000102...0f, last 13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 Decrypt, key_ready=1: key_round 11..1, first key_out 13111d7f...30c5, last 000102...0f, then key_valid=0.
REQ-035 Backpressure: key_ready=0 for 3 cycles while key_round=5 -> key_out/key_round stable, key 6 follows first accept, total 14 valid cycles.
REQ-036 wr_addr=1 while key_round=4 -> key_valid=0, busy=0, keys_ready=0 next cycle; subsequent start ignored.
REQ-037 rst asserted while key_round=7 -> all outputs at reset values next cycle; start ignored until reload.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES round-key store.
//   NUM_ROUND_KEYS : number of round keys in an AES-128 schedule (11)
//   KEY_W          : width of one round key in bits (128)
//   KEY_ADDR_W     : width of a round-key index / write address (4)
//   key_addr_t     : round-key index type; valid indices are 1..NUM_ROUND_KEYS
//   stream_state_t : state encoding of the key streaming FSM
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUND_KEYS = 11;
    localparam int KEY_W          = 128;
    localparam int KEY_ADDR_W     = 4;

    typedef logic [KEY_ADDR_W-1:0] key_addr_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_t;

    // True when an address selects a real key entry. Index 0 means "no write"
    // and anything above the key count is unused address space.
    function automatic logic addr_in_range(key_addr_t addr, int num_keys);
        return (addr != '0) && (int'(addr) <= num_keys);
    endfunction

endpackage

// File: rtl/round_key_regfile.sv
// -----------------------------------------------------------------------------
// round_key_regfile
// Storage for the expanded round keys: NUM_KEYS entries of KEY_W bits,
// indexed 1..NUM_KEYS. One synchronous write port, one combinational read
// port. A read of an out-of-range index returns zero.
//
// Ports
//   clk      in   clock; writes take effect on the rising edge
//   wr_en    in   write strobe (caller guarantees wr_addr is in range)
//   wr_addr  in   entry to write
//   wr_data  in   key to store
//   rd_addr  in   entry to read
//   rd_data  out  contents of entry rd_addr (combinational)
// -----------------------------------------------------------------------------
module round_key_regfile
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = NUM_ROUND_KEYS,
    parameter int KEY_W    = aes_pkg::KEY_W
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [KEY_ADDR_W-1:0] wr_addr,
    input  logic [KEY_W-1:0]      wr_data,
    input  logic [KEY_ADDR_W-1:0] rd_addr,
    output logic [KEY_W-1:0]      rd_data
);

    logic [KEY_W-1:0] mem [1:NUM_KEYS];

    // NOTE: the key array deliberately has no reset; a valid bitmap in the
    // parent tracks which entries hold real data, so clearing 1408 flops
    // would buy nothing and prevents the array mapping onto plain registers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_in_range(rd_addr, NUM_KEYS)) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/round_key_store.sv
// -----------------------------------------------------------------------------
// round_key_store
// Holds an AES round-key schedule written by the key expander and streams it
// to a consumer over a valid/ready handshake, in forward order (1..N) for
// encryption or reverse order (N..1) for decryption.
//
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   wr_addr     in   expander write index, 1..NUM_KEYS; 0 = no write.
//                    Index 1 starts a new schedule and aborts any stream.
//   wr_key      in   key written with wr_addr
//   wr_loaded   in   expander reports the whole schedule has been written
//   start       in   single-cycle request to stream every key
//   decrypt     in   stream order, captured with start (1 = reverse)
//   key_ready   in   consumer accepts key_out this cycle
//   key_out     out  registered round key on offer
//   key_round   out  index of key_out; 0 while key_valid is low
//   key_valid   out  key_out / key_round are valid
//   keys_ready  out  a complete schedule is held and start will be accepted
//   busy        out  a stream is in progress
// -----------------------------------------------------------------------------
module round_key_store
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = NUM_ROUND_KEYS,
    parameter int KEY_W    = aes_pkg::KEY_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_ADDR_W-1:0] wr_addr,
    input  logic [KEY_W-1:0]      wr_key,
    input  logic                  wr_loaded,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic                  key_ready,
    output logic [KEY_W-1:0]      key_out,
    output logic [KEY_ADDR_W-1:0] key_round,
    output logic                  key_valid,
    output logic                  keys_ready,
    output logic                  busy
);

    localparam key_addr_t FIRST_IDX = key_addr_t'(1);
    localparam key_addr_t LAST_IDX  = key_addr_t'(NUM_KEYS);
    // Bitmap value right after a new schedule begins: only key 1 present.
    localparam logic [NUM_KEYS:1] FIRST_ONLY = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    stream_state_t state;
    stream_state_t state_next;

    logic [NUM_KEYS:1] valid_map;   // bit i set once key i has been written
    logic              dir_dec;     // order captured at start
    logic              wr_hit;      // wr_addr selects a real entry
    logic              new_sched;   // wr_addr == 1: schedule restarts
    logic              load_first;  // stream accepted; load its first key
    logic              advance;     // transfer of a non-final key
    logic              stop;        // stream ends (final transfer or abort)
    key_addr_t         first_idx;
    key_addr_t         end_idx;
    key_addr_t         step_idx;
    key_addr_t         rd_addr;
    logic [KEY_W-1:0]  rd_data;

    assign wr_hit    = addr_in_range(wr_addr, NUM_KEYS);
    assign new_sched = (wr_addr == FIRST_IDX);
    assign busy      = (state == ST_STREAM);

    // Stream ordering. decrypt is only looked at on the start cycle; during
    // the stream the latched dir_dec steers the walk.
    assign first_idx = decrypt ? LAST_IDX  : FIRST_IDX;
    assign end_idx   = dir_dec ? FIRST_IDX : LAST_IDX;
    assign step_idx  = dir_dec ? (key_round - FIRST_IDX) : (key_round + FIRST_IDX);

    // The register file is read combinationally one cycle ahead, so the next
    // key is registered into key_out on the same edge as the transfer and
    // back-to-back keys need no bubble.
    assign rd_addr = load_first ? first_idx : step_idx;

    round_key_regfile #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_hit),
        .wr_addr (wr_addr),
        .wr_data (wr_key),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: sequential state is always written with non-blocking '<=' so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal this block drives gets a default before the case,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        advance    = 1'b0;
        stop       = 1'b0;
        case (state)
            ST_IDLE: begin
                // A schedule restart in the same cycle beats start.
                if (start && keys_ready && !new_sched) begin
                    state_next = ST_STREAM;
                    load_first = 1'b1;
                end
            end
            ST_STREAM: begin
                if (new_sched) begin
                    state_next = ST_IDLE;
                    stop       = 1'b1;
                end else if (key_valid && key_ready) begin
                    if (key_round == end_idx) begin
                        state_next = ST_IDLE;
                        stop       = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Schedule bookkeeping and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_map  <= '0;
            keys_ready <= 1'b0;
            dir_dec    <= 1'b0;
            key_valid  <= 1'b0;
            key_round  <= '0;
            key_out    <= '0;
        end else begin
            keys_ready <= wr_loaded && (&valid_map) && !new_sched;

            if (new_sched) begin
                valid_map <= FIRST_ONLY;
            end else if (wr_hit) begin
                valid_map[wr_addr] <= 1'b1;
            end

            // key_out only changes on load/advance, so it holds under
            // backpressure and ignores writes to the entry it came from.
            if (load_first) begin
                dir_dec   <= decrypt;
                key_valid <= 1'b1;
                key_round <= first_idx;
                key_out   <= rd_data;
            end else if (advance) begin
                key_round <= step_idx;
                key_out   <= rd_data;
            end else if (stop) begin
                key_valid <= 1'b0;
                key_round <= '0;
            end
        end
    end

endmodule
